// File: rtl/set_assoc_cache_ctrl_pkg.sv
// Shared types and constants for the 4-way set-associative cache controller.
package cache_pkg;
    localparam int WAYS     = 4;
    localparam int OFFSET_W = 2;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    // Tree PLRU bit layout: root chooses the pair, leaves choose within it.
    localparam int PLRU_W    = 3;
    localparam int PLRU_ROOT = 0;
    localparam int PLRU_LO   = 1;
    localparam int PLRU_HI   = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        RESP
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets);
        return ADDR_W - OFFSET_W - $clog2(sets);
    endfunction
endpackage

// File: rtl/set_assoc_cache_ctrl_if.sv
// Processor-side request/response and RAM-side request/acknowledge bundle.
interface set_assoc_cache_ctrl_if;
    import cache_pkg::*;

    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_resp_valid;
    logic [DATA_W-1:0] cpu_resp_rdata;
    logic              cpu_resp_hit;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  mem_resp_valid, mem_resp_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output mem_resp_valid, mem_resp_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/set_assoc_cache_ctrl_plru4.sv
// Tree pseudo-LRU for one 4-way set: victim pick and post-access update.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle on the indexed set.
module plru4
    import cache_pkg::*;
(
    input  logic [PLRU_W-1:0] plru_bits,
    input  logic [1:0]        touch_way,
    output logic [1:0]        victim,
    output logic [PLRU_W-1:0] plru_nxt
);

    always_comb begin
        victim = {plru_bits[PLRU_ROOT],
                  plru_bits[PLRU_ROOT] ? plru_bits[PLRU_HI] : plru_bits[PLRU_LO]};
    end

    // Point every node on the touched path away from the touched way.
    always_comb begin
        plru_nxt            = plru_bits;
        plru_nxt[PLRU_ROOT] = ~touch_way[1];
        if (!touch_way[1]) begin
            plru_nxt[PLRU_LO] = ~touch_way[0];
        end else begin
            plru_nxt[PLRU_HI] = ~touch_way[0];
        end
    end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// 4-way set-associative, write-through, read-allocate cache controller.
// Latency: read hit answers 2 cycles after accept; misses/writes answer 1 cycle after RAM ack.
// Backpressure: single outstanding request; ready only in IDLE, response is a non-stallable pulse.
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int SETS = 256
)
(
    input  logic                  clk,
    input  logic                  rst,
    set_assoc_cache_ctrl_if.slave bus
);

    localparam int INDEX_W = index_w(SETS);
    localparam int TAG_W   = tag_w(SETS);

    state_t state, state_nxt;
    req_t   req_q;

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]   valid_q;
    logic [SETS-1:0][PLRU_W-1:0] plru_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WAYS-1:0]    hit_vec;
    logic               hit;
    logic               any_inv;
    logic [1:0]         hit_way, inv_way, plru_victim, victim, touch_way;
    logic [PLRU_W-1:0]  plru_nxt;
    logic               accept, mem_ack, fill, touch;

    assign idx = req_q.addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign tag = req_q.addr[ADDR_W-1:INDEX_W+OFFSET_W];

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        any_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid_q[idx][w] && (tag_mem[idx][w] == tag);
            if (hit_vec[w]) begin
                hit_way = 2'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_way = 2'(w);
                any_inv = 1'b1;
            end
        end
    end

    assign hit       = |hit_vec;
    assign victim    = any_inv ? inv_way : plru_victim;
    assign touch_way = (state == MEM_RD) ? victim : hit_way;

    plru4 u_plru (
        .plru_bits (plru_q[idx]),
        .touch_way (touch_way),
        .victim    (plru_victim),
        .plru_nxt  (plru_nxt)
    );

    assign accept  = (state == IDLE) && bus.cpu_req_valid;
    assign mem_ack = ((state == MEM_RD) || (state == MEM_WR)) && bus.mem_resp_valid;
    assign fill    = (state == MEM_RD) && bus.mem_resp_valid;
    assign touch   = ((state == LOOKUP) && hit) || fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        bus.cpu_req_ready  = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_q.we) begin
                    state_nxt = MEM_WR;
                end else if (hit) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = MEM_RD;
                end
            end
            MEM_RD, MEM_WR: begin
                if (bus.mem_resp_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.cpu_resp_valid = 1'b1;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{we: bus.cpu_req_we, addr: bus.cpu_req_addr, wdata: bus.cpu_req_wdata};
        end
    end

    // RAM request fields are launched once from LOOKUP and held until the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_req_valid  <= 1'b0;
            bus.mem_req_we     <= 1'b0;
            bus.mem_req_addr   <= '0;
            bus.mem_req_wdata  <= '0;
            bus.cpu_resp_rdata <= '0;
            bus.cpu_resp_hit   <= 1'b0;
        end else begin
            if (state == LOOKUP) begin
                bus.cpu_resp_hit   <= hit;
                bus.cpu_resp_rdata <= (!req_q.we && hit) ? data_mem[idx][hit_way] : '0;
                if (req_q.we || !hit) begin
                    bus.mem_req_valid <= 1'b1;
                    bus.mem_req_we    <= req_q.we;
                    bus.mem_req_addr  <= req_q.addr & ~ADDR_W'(3);
                    bus.mem_req_wdata <= req_q.we ? req_q.wdata : '0;
                end
            end
            if (fill) begin
                bus.cpu_resp_rdata <= bus.mem_resp_rdata;
            end
            if (mem_ack) begin
                bus.mem_req_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == LOOKUP) && hit && req_q.we) begin
            data_mem[idx][hit_way] <= req_q.wdata;
        end
        if (fill) begin
            tag_mem[idx][victim]  <= tag;
            data_mem[idx][victim] <= bus.mem_resp_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else begin
            if (fill) begin
                valid_q[idx][victim] <= 1'b1;
            end
            if (touch) begin
                plru_q[idx] <= plru_nxt;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) (state == LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: doc/set_assoc_cache_ctrl.md
# set_assoc_cache_ctrl

Controller for the 4-way set-associative, one-word-per-line cache. It accepts processor read/write requests, performs tag lookup across all four ways and answers hits from the cache. On a read miss it refills from backing RAM through a request/acknowledge handshake, choosing the victim by invalid-first then tree pseudo-LRU. Writes go through to RAM, with no allocate on a write miss. It sits between the processor request port and the RAM model, and owns the tag, valid, data and PLRU arrays.

## Interface
- SETS, 256, number of sets; power of two; INDEX_W = log2(SETS), TAG_W = 30 - INDEX_W (22 at default)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req_valid  in  1  processor request present
- cpu_req_ready  out  1  controller can accept; high only in IDLE
- cpu_req_we  in  1  0 = read, 1 = write
- cpu_req_addr  in  32  byte address; [1:0] ignored, index = [INDEX_W+1:2], tag = [31:INDEX_W+2]
- cpu_req_wdata  in  32  write data
- cpu_resp_valid  out  1  one-cycle response pulse, no backpressure
- cpu_resp_rdata  out  32  read data; 0 for writes
- cpu_resp_hit  out  1  lookup result of the answered request
- mem_req_valid  out  1  RAM request, held until acknowledged
- mem_req_we  out  1  0 = read, 1 = write
- mem_req_addr  out  32  word-aligned address ([1:0] = 0)
- mem_req_wdata  out  32  write data
- mem_resp_valid  in  1  RAM acknowledge; for reads, carries data that cycle
- mem_resp_rdata  in  32  RAM read data

## Operation
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE: ready = 1. When valid & ready, latch we/addr/wdata and go to LOOKUP.
- LOOKUP: compare the latched tag against all 4 ways of the set; hit = valid & tag match. At most one way can hit; a multi-hit is an assertion failure.
  - read hit → RESP, rdata = hit way data, PLRU touched.
  - read miss → MEM_RD.
  - write hit: update that way's data, touch PLRU, go to MEM_WR.
  - write miss → MEM_WR; cache unchanged.
- MEM_RD / MEM_WR: mem_req_valid = 1 with addr, we and wdata stable. On mem_resp_valid, leave the state.
  - For MEM_RD, write the victim way (valid = 1, tag, data = mem_resp_rdata), touch PLRU, capture rdata.
  - Next state is RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Victim selection: lowest-numbered invalid way; if all four are valid, use PLRU.
- PLRU uses 3 bits per set:
  - b0 = 0 means the victim is in {0,1}, b0 = 1 means {2,3}.
  - b1 picks within {0,1}; b2 picks within {2,3}.
  - Touching way w sets b0 = ~w[1]; if w[1] = 0 then b1 = ~w[0], else b2 = ~w[0].
- Reset:
  - All valid bits and PLRU bits are cleared; tag/data arrays are not reset.
  - State = IDLE.
  - Outputs: cpu_req_ready = 1, cpu_resp_valid = 0, cpu_resp_rdata = 0, cpu_resp_hit = 0, mem_req_valid = 0, mem_req_we = 0, mem_req_addr = 0, mem_req_wdata = 0.
- Reset mid-operation aborts the transaction with no response. mem_req_valid drops asynchronously, and the RAM must discard the abandoned request.
- mem_resp_valid outside MEM_RD/MEM_WR is ignored.

## Timing
- Request accepted at edge T. LOOKUP occupies cycle T+1.
- Read hit: resp_valid during cycle T+2; ready again at T+3.
- Miss and write:
  - mem_req_valid asserts in cycle T+2.
  - If the acknowledge arrives in cycle A, resp_valid is in cycle A+1 and ready in A+2.
  - Zero-wait RAM (ack in T+2) gives response at T+3.
- mem_req_* are registered outputs and never change while mem_req_valid = 1 and unacknowledged.
- At most one outstanding request on each side; no pipelining.

## Structure
- Shared package cache_pkg holds:
  - WAYS = 4, OFFSET_W = 2, the state enum.
  - Tag and index width functions of SETS.
  - The PLRU bit-layout constants.
- One sub-module, plru4. It is combinational: 3-bit state in → victim way, plus way in → next state. It is instantiated once on the indexed set's bits.
- Tag compare and hit-way encode stay inline.

## Test plan
- Reset, read 0x0000_2828 (index 10, tag 10) → mem_req_valid at T+2 with addr 0x2828; ack with 15000 three cycles later → resp rdata 15000, hit 0; way 0 filled.
- Read 0x2828 again → resp_valid at T+2, hit 1, rdata 15000, mem_req_valid never asserted.
- Read misses to 0x2C28, 0x3028, 0x3428 (tags 11–13), then 0x3828 (tag 14):
  - The tag 14 refill replaces way 0 (PLRU b0 = 0, b1 = 0).
  - A following read of 0x2828 misses.
- Write hit 0x2C28 data 0xDEAD → MEM_WR with we 1, addr 0x2C28, wdata 0xDEAD, resp hit 1. The next read hits with 0xDEAD.
- Write miss 0x4028 → RAM write only, resp hit 0. The next read of 0x4028 misses.
- Assert rst while in MEM_RD with the ack withheld:
  - mem_req_valid falls without waiting for a clock edge; no resp_valid.
  - After release, ready = 1 and the previously hitting 0x2828 misses.
  - cpu_req_valid held high during the miss is not accepted until IDLE.
